// File: rtl/varredura_colunas_matriz.sv
// Column-scan controller for the 5x7 irrigation-status LED matrix.
// One-hot column drive with per-slot blanking and frame-latched mode pair.
module varredura_colunas_matriz #(
    parameter int DIV   = 4,
    parameter int BLANK = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       aspersao_in,
    input  logic       gotejamento_in,
    output logic [4:0] col,
    output logic       aspersao,
    output logic       gotejamento,
    output logic       frame_start,
    output logic       blank
);

    localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [2:0]    IDX_LAST = 3'd4;

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic          running;
    logic [1:0]    asp_sync;
    logic [1:0]    got_sync;
    logic          in_blank;
    logic          frame_end;

    // Raw mode requests are asynchronous; two flops before any use.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            asp_sync <= 2'b00;
            got_sync <= 2'b00;
        end else begin
            asp_sync <= {asp_sync[0], aspersao_in};
            got_sync <= {got_sync[0], gotejamento_in};
        end
    end

    assign frame_end = (idx == IDX_LAST) && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            idx         <= '0;
            running     <= 1'b0;
            aspersao    <= 1'b0;
            gotejamento <= 1'b0;
        end else if (!en) begin
            cnt     <= '0;
            idx     <= '0;
            running <= 1'b0;
        end else if (!running || frame_end) begin
            cnt         <= '0;
            idx         <= '0;
            running     <= 1'b1;
            aspersao    <= asp_sync[1];
            gotejamento <= got_sync[1];
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= idx + 3'd1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    generate
        if (BLANK == 0) begin : g_noblank
            assign in_blank = 1'b0;
        end else begin : g_blank
            localparam logic [CW-1:0] BLANK_C = CW'(BLANK);
            assign in_blank = (cnt < BLANK_C);
        end
    endgenerate

    assign col         = (running && !in_blank) ? (5'b00001 << idx) : 5'b00000;
    assign blank       = running && in_blank;
    assign frame_start = running && (idx == 3'd0) && (cnt == '0);

endmodule

// File: tb/tb_varredura_colunas_matriz.sv
// Directed bench for varredura_colunas_matriz: default DIV=4/BLANK=1
// instance plus a DIV=2/BLANK=0 instance.
module tb_varredura_colunas_matriz;

    logic       clk;
    logic       reset;
    logic       en;
    logic       asp_in;
    logic       got_in;
    logic [4:0] col;
    logic       asp;
    logic       got;
    logic       fs;
    logic       blk;

    logic       en2;
    logic       asp_in2;
    logic       got_in2;
    logic [4:0] col2;
    logic       asp2;
    logic       got2;
    logic       fs2;
    logic       blk2;

    int compared   = 0;
    int mismatched = 0;

    varredura_colunas_matriz #(.DIV(4), .BLANK(1)) dut (
        .clk            (clk),
        .reset          (reset),
        .en             (en),
        .aspersao_in    (asp_in),
        .gotejamento_in (got_in),
        .col            (col),
        .aspersao       (asp),
        .gotejamento    (got),
        .frame_start    (fs),
        .blank          (blk)
    );

    varredura_colunas_matriz #(.DIV(2), .BLANK(0)) dut2 (
        .clk            (clk),
        .reset          (reset),
        .en             (en2),
        .aspersao_in    (asp_in2),
        .gotejamento_in (got_in2),
        .col            (col2),
        .aspersao       (asp2),
        .gotejamento    (got2),
        .frame_start    (fs2),
        .blank          (blk2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [4:0] obs,
                       input logic [4:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Expected column for position p inside a frame.
    function automatic logic [4:0] exp_col(input int p, input int div,
                                           input int bl);
        logic [4:0] one;
        one = 5'b00001;
        if ((p % div) < bl) return 5'b00000;
        return one << (p / div);
    endfunction

    // One edge of the default instance, checked at position p.
    task automatic scan_step(input int p, input logic ea, input logic eg);
        @(posedge clk);
        #1;
        chk($sformatf("col p%0d", p), col, exp_col(p, 4, 1));
        chk($sformatf("blank p%0d", p), {4'b0, blk}, {4'b0, (p % 4) == 0});
        chk($sformatf("fs p%0d", p), {4'b0, fs}, {4'b0, p == 0});
        chk($sformatf("asp p%0d", p), {4'b0, asp}, {4'b0, ea});
        chk($sformatf("got p%0d", p), {4'b0, got}, {4'b0, eg});
    endtask

    task automatic idle_chk(input string tag, input logic em);
        chk({tag, " col"}, col, 5'b00000);
        chk({tag, " blank"}, {4'b0, blk}, 5'b0);
        chk({tag, " fs"}, {4'b0, fs}, 5'b0);
        chk({tag, " asp"}, {4'b0, asp}, {4'b0, em});
        chk({tag, " got"}, {4'b0, got}, {4'b0, em});
    endtask

    initial begin
        reset   = 1'b1;
        en      = 1'b1;
        asp_in  = 1'b1;
        got_in  = 1'b0;
        en2     = 1'b0;
        asp_in2 = 1'b0;
        got_in2 = 1'b0;

        // Held in reset with en=1 and a raw mode request pending.
        repeat (3) begin
            @(posedge clk);
            #1;
            idle_chk("rst", 1'b0);
        end

        // Free-running scan; aspersao lands at the second frame start,
        // gotejamento (raised at idx=2) at the third.
        reset = 1'b0;
        for (int k = 0; k <= 54; k++) begin
            scan_step(k % 20, k >= 20, k >= 40);
            if (k == 30) got_in = 1'b1;
        end

        // Now at idx=3, cnt=2: drop en for 3 cycles.
        en = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            idle_chk("en_off", 1'b1);
        end

        // Re-enable restarts at column 0 with a fresh frame_start.
        en = 1'b1;
        for (int p = 0; p <= 7; p++) scan_step(p, 1'b1, 1'b1);

        // At idx=1, cnt=3: reset acts without an edge.
        #2;
        reset = 1'b1;
        #1;
        idle_chk("async_rst", 1'b0);
        @(posedge clk);
        #1;
        idle_chk("rst_hold", 1'b0);
        reset = 1'b0;
        for (int k = 0; k <= 20; k++) scan_step(k % 20, k >= 20, k >= 20);

        // DIV=2, BLANK=0 instance: idle so far, then a 10-cycle frame.
        chk("d2 idle col", col2, 5'b00000);
        en2 = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("d2 col k%0d", k), col2, exp_col(k % 10, 2, 0));
            chk($sformatf("d2 blank k%0d", k), {4'b0, blk2}, 5'b0);
            chk($sformatf("d2 fs k%0d", k), {4'b0, fs2}, {4'b0, (k % 10) == 0});
        end
        chk("d2 asp", {3'b0, asp2, got2}, 5'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
